// File: rtl/round_tally_pkg.sv
// rtl/round_tally_pkg.sv - shared match states, BCD limits and BCD helpers
package round_tally_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAYING = 2'd1,
        ST_OVER    = 2'd2
    } match_state_t;

    localparam logic [7:0] BCD_MAX = 8'h99;

    // Saturating two-digit BCD increment; 99 stays at 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == BCD_MAX)
            r = v;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = 4'(v / 10);
        units = 4'(v % 10);
        return {tens, units};
    endfunction

endpackage

// File: rtl/bcd_counter2.sv
// rtl/bcd_counter2.sv - two-digit saturating BCD counter with clear and increment
module bcd_counter2
    import round_tally_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clr)
            count <= 8'h00;
        else if (inc)
            count <= bcd_inc(count);
    end

endmodule

// File: rtl/round_tally.sv
// rtl/round_tally.sv - per-match round tally with BCD win/tie/round counters
module round_tally
    import round_tally_pkg::*;
#(
    parameter int WIN_TARGET = 5
) (
    input  logic       slow_clock,
    input  logic       reset,
    input  logic       endround,
    input  logic       player_win_light,
    input  logic       dealer_win_light,
    input  logic       new_match,
    output logic [7:0] player_wins,
    output logic [7:0] dealer_wins,
    output logic [7:0] ties,
    output logic [7:0] rounds,
    output logic       match_player,
    output logic       match_dealer,
    output logic       round_done
);

    localparam logic [7:0] TARGET_BCD = to_bcd(WIN_TARGET);

    match_state_t state;
    logic         endround_q;
    logic         detect;
    logic         record;
    logic         player_inc;
    logic         dealer_inc;
    logic         tie_inc;
    logic         hit_player;
    logic         hit_dealer;

    // new_match wins over a coincident round, so the round is never recorded.
    assign detect     = endround && !endround_q;
    assign record     = detect && (state != ST_OVER) && !new_match;
    assign player_inc = record && player_win_light && !dealer_win_light;
    assign dealer_inc = record && dealer_win_light && !player_win_light;
    assign tie_inc    = record && player_win_light && dealer_win_light;
    assign hit_player = player_inc && (bcd_inc(player_wins) == TARGET_BCD);
    assign hit_dealer = dealer_inc && (bcd_inc(dealer_wins) == TARGET_BCD);

    bcd_counter2 u_player (.clk(slow_clock), .reset(reset), .clr(new_match), .inc(player_inc), .count(player_wins));
    bcd_counter2 u_dealer (.clk(slow_clock), .reset(reset), .clr(new_match), .inc(dealer_inc), .count(dealer_wins));
    bcd_counter2 u_ties   (.clk(slow_clock), .reset(reset), .clr(new_match), .inc(tie_inc),    .count(ties));
    bcd_counter2 u_rounds (.clk(slow_clock), .reset(reset), .clr(new_match), .inc(record),     .count(rounds));

    // History resets high so an endround already high at release is not a round.
    always_ff @(posedge slow_clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            endround_q   <= 1'b1;
            match_player <= 1'b0;
            match_dealer <= 1'b0;
            round_done   <= 1'b0;
        end else begin
            endround_q <= endround;
            round_done <= record;
            if (new_match) begin
                state        <= ST_IDLE;
                match_player <= 1'b0;
                match_dealer <= 1'b0;
            end else if (record) begin
                if (hit_player) begin
                    state        <= ST_OVER;
                    match_player <= 1'b1;
                end else if (hit_dealer) begin
                    state        <= ST_OVER;
                    match_dealer <= 1'b1;
                end else begin
                    state <= ST_PLAYING;
                end
            end
        end
    end

endmodule

// File: doc/round_tally.md
ROUND_TALLY -- requirements
Module: round_tally

Interface
REQ-001 Parameter: WIN_TARGET, default 5, round wins needed to take a match (legal 1..99).
REQ-002 Port: slow_clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: endround  input  1  high while the round controller is in its end-of-round state.
REQ-005 Port: player_win_light  input  1  player won or tied, valid while endround high.
REQ-006 Port: dealer_win_light  input  1  dealer won or tied, valid while endround high.
REQ-007 Port: new_match  input  1  single-cycle request to clear tallies and start a new match.
REQ-008 Port: player_wins  output  8  two BCD digits [7:4]=tens, [3:0]=units.
REQ-009 Port: dealer_wins  output  8  two BCD digits.
REQ-010 Port: ties  output  8  two BCD digits.
REQ-011 Port: rounds  output  8  two BCD digits, rounds counted this match.
REQ-012 Port: match_player  output  1  player took the match.
REQ-013 Port: match_dealer  output  1  dealer took the match.
REQ-014 Port: round_done  output  1  one-cycle pulse, cycle after a round is recorded.

Function
REQ-015 A round SHALL be detected on the rising edge of endround (endround high now, low on previous sample); a level held high SHALL count once only.
REQ-016 Classification SHALL use win lights sampled in the detection cycle: player only -> player win; dealer only -> dealer win; both -> tie; neither -> round counted, no win/tie increment.
REQ-017 Each counter SHALL increment in BCD (units 9 -> 0 with tens carry) and saturate at 99.
REQ-018 rounds SHALL increment by one for every recorded round, saturating at 99.
REQ-019 State machine SHALL have states IDLE, PLAYING, OVER.
REQ-020 IDLE: counters zero; first detected round -> record round, enter PLAYING.
REQ-021 PLAYING: record each detected round; if the incremented player or dealer count equals WIN_TARGET -> enter OVER.
REQ-022 OVER: detected rounds SHALL be ignored (no counter change, no round_done).
REQ-023 match_player SHALL be high exactly while in OVER with player_wins = WIN_TARGET; likewise match_dealer; never both.
REQ-024 new_match in any state SHALL zero all counters and flags and enter IDLE next cycle.
REQ-025 new_match coincident with a detected round SHALL take priority; the round is discarded and round_done stays low.
REQ-026 Counter update and state transition SHALL become visible on outputs one cycle after the detecting edge; round_done SHALL pulse in that same cycle.
REQ-027 WIN_TARGET comparison SHALL be against the BCD-encoded target.

Reset
REQ-028 reset SHALL force IDLE, all counters 8'h00, match_player=0, match_dealer=0, round_done=0, edge-detect history=1 (so endround high at reset release is not counted).
REQ-029 reset asserted mid-round SHALL override any pending record; reset has priority over new_match.

Structure
REQ-030 State encodings and BCD max constant (8'h99) SHALL live in a shared package used by the round controller and this block.
REQ-031 One sub-module, bcd_counter2 (2-digit saturating BCD counter with inc and clr), SHALL be instantiated four times.
REQ-032 Outputs SHALL be registered; no combinational path from inputs to outputs.

Verification
REQ-033 Reset, endround held high 3 cycles with player light only -> player_wins=8'h01, rounds=8'h01, one round_done pulse.
REQ-034 Both lights on 12 rounds -> ties=8'h12, rounds=8'h12, player_wins=dealer_wins=8'h00.
REQ-035 WIN_TARGET=5, five dealer-only rounds -> OVER, match_dealer=1; sixth round -> all counters unchanged, no round_done.
REQ-036 Force player_wins to 8'h99 (WIN_TARGET=99 not reached via ties first): extra player round -> stays 8'h99; 9 -> 10 carry gives 8'h10, not 8'h0A.
REQ-037 new_match on same cycle as endround rising edge -> all counters 8'h00, IDLE, round_done=0.
REQ-038 Reset asserted while endround high and released with endround still high -> no count until endround falls and rises again.
